// File: rtl/snn_pkg.sv
// rtl/snn_pkg.sv - shared types and network dimensions for the SNN layer sequencer
package snn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLR,
        ST_MAC,
        ST_BP,
        ST_WRITE,
        ST_DONE
    } layer_state_t;

    localparam int NUM_INPUT  = 784;
    localparam int NUM_HIDDEN = 32;
    localparam int NUM_OUTPUT = 10;

    // Hidden layer: 784 inputs -> 32 neurons
    localparam int IN_AW_L1  = $clog2(NUM_INPUT);
    localparam int OUT_AW_L1 = $clog2(NUM_HIDDEN);
    localparam int WT_AW_L1  = $clog2(NUM_INPUT * NUM_HIDDEN);

    // Output layer: 32 hidden -> 10 neurons
    localparam int IN_AW_L2  = $clog2(NUM_HIDDEN);
    localparam int OUT_AW_L2 = $clog2(NUM_OUTPUT);
    localparam int WT_AW_L2  = $clog2(NUM_HIDDEN * NUM_OUTPUT);

endpackage

// File: rtl/snn_valid_pipe.sv
// rtl/snn_valid_pipe.sv - fixed-depth valid delay line matching the ROM/MAC read latency
module snn_valid_pipe
    import snn_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic vin,
    output logic vout
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    // Shift the issue bit one stage per cycle; bit 0 takes the fresh issue
    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = vin;
        for (int i = 1; i < DEPTH; i++) begin
            sr_d[i] = sr_q[i-1];
        end
    end

    // Synchronous clear drops any in-flight valids
    always_ff @(posedge clk) begin
        if (clr) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign vout = sr_q[DEPTH-1];

endmodule

// File: rtl/snn_layer_seq.sv
// rtl/snn_layer_seq.sv - per-layer neuron/input walk driving MAC clear, accumulate and result write
module snn_layer_seq
    import snn_pkg::*;
#(
    parameter int NUM_IN = NUM_INPUT,
    parameter int NUM_OUT = NUM_HIDDEN,
    parameter int RD_LAT = 2,
    parameter int IN_AW = 10,
    parameter int OUT_AW = 5,
    parameter int WT_AW = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [IN_AW-1:0]  in_addr,
    output logic [WT_AW-1:0]  wt_addr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              wr_en,
    output logic [OUT_AW-1:0] wr_addr
);

    localparam int BP_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [IN_AW-1:0]  IN_LAST  = IN_AW'(NUM_IN - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(NUM_OUT - 1);
    localparam logic [BP_W-1:0]   BP_LAST  = BP_W'(RD_LAT - 1);

    layer_state_t      state_q, state_d;
    logic [IN_AW-1:0]  in_idx_q, in_idx_d;
    logic [OUT_AW-1:0] out_idx_q, out_idx_d;
    logic [WT_AW-1:0]  wt_idx_q, wt_idx_d;
    logic [IN_AW-1:0]  in_hold_q, in_hold_d;
    logic [WT_AW-1:0]  wt_hold_q, wt_hold_d;
    logic [BP_W-1:0]   bp_cnt_q, bp_cnt_d;
    logic              issue;

    // Next-state and outputs; addresses show the live counters in MAC and the last issued value elsewhere
    always_comb begin
        state_d   = state_q;
        in_idx_d  = in_idx_q;
        out_idx_d = out_idx_q;
        wt_idx_d  = wt_idx_q;
        in_hold_d = in_hold_q;
        wt_hold_d = wt_hold_q;
        bp_cnt_d  = bp_cnt_q;
        issue     = 1'b0;
        mac_clr   = 1'b0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        done      = 1'b0;
        busy      = (state_q != ST_IDLE);
        in_addr   = in_hold_q;
        wt_addr   = wt_hold_q;
        case (state_q)
            ST_IDLE: begin
                in_addr = '0;
                wt_addr = '0;
                if (start) begin
                    state_d   = ST_CLR;
                    in_idx_d  = '0;
                    out_idx_d = '0;
                    wt_idx_d  = '0;
                    in_hold_d = '0;
                    wt_hold_d = '0;
                end
            end
            ST_CLR: begin
                mac_clr = 1'b1;
                state_d = ST_MAC;
            end
            ST_MAC: begin
                issue     = 1'b1;
                in_addr   = in_idx_q;
                wt_addr   = wt_idx_q;
                in_hold_d = in_idx_q;
                wt_hold_d = wt_idx_q;
                wt_idx_d  = wt_idx_q + WT_AW'(1);
                if (in_idx_q == IN_LAST) begin
                    in_idx_d = '0;
                    bp_cnt_d = '0;
                    state_d  = ST_BP;
                end else begin
                    in_idx_d = in_idx_q + IN_AW'(1);
                end
            end
            ST_BP: begin
                if (bp_cnt_q == BP_LAST) begin
                    bp_cnt_d = '0;
                    state_d  = ST_WRITE;
                end else begin
                    bp_cnt_d = bp_cnt_q + BP_W'(1);
                end
            end
            ST_WRITE: begin
                wr_en   = 1'b1;
                wr_addr = out_idx_q;
                if (out_idx_q == OUT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    out_idx_d = out_idx_q + OUT_AW'(1);
                    state_d   = ST_CLR;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            in_idx_q  <= '0;
            out_idx_q <= '0;
            wt_idx_q  <= '0;
            in_hold_q <= '0;
            wt_hold_q <= '0;
            bp_cnt_q  <= '0;
        end else begin
            state_q   <= state_d;
            in_idx_q  <= in_idx_d;
            out_idx_q <= out_idx_d;
            wt_idx_q  <= wt_idx_d;
            in_hold_q <= in_hold_d;
            wt_hold_q <= wt_hold_d;
            bp_cnt_q  <= bp_cnt_d;
        end
    end

    snn_valid_pipe #(
        .DEPTH(RD_LAT)
    ) u_valid_pipe (
        .clk (clk),
        .clr (rst),
        .vin (issue),
        .vout(mac_en)
    );

endmodule
